// File: rtl/reaction_referee.sv
// Two-player reaction timer referee.
// A round runs blink -> random dark wait -> visible ms count. Presses in the dark
// wait are cheats; the first rising press edge in the count wins. Scores are
// thermometer codes that survive rounds and clear only on reset.
module reaction_referee #(
  parameter int BLINK_MS    = 3000,
  parameter int MIN_WAIT_MS = 1000,
  parameter int MAX_RAND_MS = 5000,
  parameter int TIMEOUT_MS  = 9999,
  parameter int SCORE_W     = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ms_tick,
  input  logic               start,
  input  logic [13:0]        rnd_value,
  input  logic               p1_press,
  input  logic               p2_press,
  output logic [1:0]         disp_sel,
  output logic [3:0]         fill_digit,
  output logic [19:0]        elapsed_ms,
  output logic [19:0]        winner_time,
  output logic [1:0]         winner_id,
  output logic [SCORE_W-1:0] score1,
  output logic [SCORE_W-1:0] score2,
  output logic               busy
);

  // state    | meaning
  // S_IDLE   | after reset, blank display, waiting for start
  // S_BLINK  | blink pattern, counting BLINK_MS ticks, presses ignored
  // S_WAIT   | dark random wait; any press level is a cheat
  // S_TIMING | visible ms count; first rising press edge wins
  // S_WIN    | result shown (winner, tie or timeout), elapsed frozen
  // S_CHEAT  | cheat result shown via fill digit
  typedef enum logic [2:0] {
    S_IDLE, S_BLINK, S_WAIT, S_TIMING, S_WIN, S_CHEAT
  } state_t;

  localparam logic [1:0] DSP_BLINK = 2'd0;
  localparam logic [1:0] DSP_FILL  = 2'd1;
  localparam logic [1:0] DSP_ELAP  = 2'd2;
  localparam logic [1:0] DSP_WIN   = 2'd3;

  state_t       state;
  logic [15:0]  ms_cnt;
  logic [14:0]  wait_target;
  logic         p1_q;
  logic         p2_q;

  logic [15:0]  ms_next;
  logic [19:0]  elapsed_next;
  logic [13:0]  rnd_clamped;
  logic [14:0]  wait_calc;
  logic         rise1;
  logic         rise2;

  // Saturating thermometer increment: shifting in a one leaves all-ones unchanged.
  function automatic logic [SCORE_W-1:0] therm_inc(input logic [SCORE_W-1:0] s);
    return {s[SCORE_W-2:0], 1'b1};
  endfunction

  // Next-count values, clamped wait length and press rising edges.
  always_comb begin
    ms_next      = ms_cnt + 16'd1;
    elapsed_next = elapsed_ms + 20'd1;
    rnd_clamped  = (rnd_value > 14'(MAX_RAND_MS)) ? 14'(MAX_RAND_MS) : rnd_value;
    wait_calc    = 15'(MIN_WAIT_MS) + {1'b0, rnd_clamped};
    rise1        = p1_press & ~p1_q;
    rise2        = p2_press & ~p2_q;
  end

  // Round sequencing with all outputs registered; start overrides every state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      ms_cnt      <= '0;
      wait_target <= '0;
      p1_q        <= 1'b0;
      p2_q        <= 1'b0;
      disp_sel    <= DSP_FILL;
      fill_digit  <= 4'hF;
      elapsed_ms  <= '0;
      winner_time <= '0;
      winner_id   <= 2'd0;
      score1      <= '0;
      score2      <= '0;
      busy        <= 1'b0;
    end else begin
      p1_q <= p1_press;
      p2_q <= p2_press;
      if (start) begin
        state       <= S_BLINK;
        ms_cnt      <= '0;
        elapsed_ms  <= '0;
        winner_time <= '0;
        winner_id   <= 2'd0;
        disp_sel    <= DSP_BLINK;
        fill_digit  <= 4'hF;
        busy        <= 1'b1;
      end else begin
        case (state)
          S_BLINK: begin
            if (ms_tick) begin
              if (ms_next == 16'(BLINK_MS)) begin
                wait_target <= wait_calc;
                ms_cnt      <= '0;
                state       <= S_WAIT;
                disp_sel    <= DSP_FILL;
                fill_digit  <= 4'hF;
              end else begin
                ms_cnt <= ms_next;
              end
            end
          end
          S_WAIT: begin
            if (p1_press || p2_press) begin
              state    <= S_CHEAT;
              busy     <= 1'b0;
              ms_cnt   <= '0;
              disp_sel <= DSP_FILL;
              if (p1_press && p2_press) begin
                fill_digit <= 4'd8;
              end else if (p1_press) begin
                fill_digit <= 4'd1;
                score2     <= therm_inc(score2);
              end else begin
                fill_digit <= 4'd2;
                score1     <= therm_inc(score1);
              end
            end else if (ms_tick) begin
              if (ms_next == {1'b0, wait_target}) begin
                ms_cnt     <= '0;
                state      <= S_TIMING;
                disp_sel   <= DSP_ELAP;
                elapsed_ms <= '0;
              end else begin
                ms_cnt <= ms_next;
              end
            end
          end
          S_TIMING: begin
            if (rise1 || rise2) begin
              state       <= S_WIN;
              busy        <= 1'b0;
              disp_sel    <= DSP_WIN;
              winner_time <= elapsed_ms;
              if (rise1 && rise2) begin
                winner_id <= 2'd3;
              end else if (rise1) begin
                winner_id <= 2'd1;
                score1    <= therm_inc(score1);
              end else begin
                winner_id <= 2'd2;
                score2    <= therm_inc(score2);
              end
            end else if (ms_tick) begin
              if (elapsed_next == 20'(TIMEOUT_MS)) begin
                elapsed_ms  <= 20'(TIMEOUT_MS);
                winner_time <= 20'(TIMEOUT_MS);
                winner_id   <= 2'd0;
                state       <= S_WIN;
                busy        <= 1'b0;
                disp_sel    <= DSP_WIN;
              end else begin
                elapsed_ms <= elapsed_next;
              end
            end
          end
          default: begin
            // IDLE, WIN and CHEAT hold their outputs until start or reset.
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_reaction_referee.sv
// Directed bench for reaction_referee: phase lengths, clamp, cheats, ties,
// timeout, score saturation, reset and start priority.
module tb_reaction_referee;

  logic        clk = 1'b0;
  logic        reset;
  logic        ms_tick;
  logic        start;
  logic [13:0] rnd_value;
  logic        p1_press;
  logic        p2_press;
  logic [1:0]  disp_sel;
  logic [3:0]  fill_digit;
  logic [19:0] elapsed_ms;
  logic [19:0] winner_time;
  logic [1:0]  winner_id;
  logic [4:0]  score1;
  logic [4:0]  score2;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  logic [4:0] therm [0:6];

  reaction_referee dut (
    .clk         (clk),
    .reset       (reset),
    .ms_tick     (ms_tick),
    .start       (start),
    .rnd_value   (rnd_value),
    .p1_press    (p1_press),
    .p2_press    (p2_press),
    .disp_sel    (disp_sel),
    .fill_digit  (fill_digit),
    .elapsed_ms  (elapsed_ms),
    .winner_time (winner_time),
    .winner_id   (winner_id),
    .score1      (score1),
    .score2      (score2),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are read at the same point.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    ms_tick = 1'b1;
    repeat (n) step();
    ms_tick = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();
  endtask

  initial begin
    therm[0] = 5'b00001; therm[1] = 5'b00011; therm[2] = 5'b00111;
    therm[3] = 5'b01111; therm[4] = 5'b11111; therm[5] = 5'b11111;
    therm[6] = 5'b11111;
    ms_tick = 0; start = 0; rnd_value = 14'd500; p1_press = 0; p2_press = 0;
    reset = 1'b1;
    #2;
    step();
    check("rst_disp_sel", disp_sel, 2'd1);
    check("rst_fill", fill_digit, 4'hF);
    check("rst_elapsed", elapsed_ms, 0);
    check("rst_winner_id", winner_id, 0);
    check("rst_scores", {score1, score2}, 0);
    check("rst_busy", busy, 0);
    reset = 1'b0;
    step();

    // 1: blink 3000, wait 1500, P1 rises 237 ticks into timing
    rnd_value = 14'd500;
    pulse_start();
    check("t1_blink_disp", disp_sel, 2'd0);
    check("t1_busy", busy, 1);
    ticks(2999);
    check("t1_blink_2999", disp_sel, 2'd0);
    ticks(1);
    check("t1_wait_enter", disp_sel, 2'd1);
    check("t1_wait_fill", fill_digit, 4'hF);
    ticks(1499);
    check("t1_wait_1499", disp_sel, 2'd1);
    ticks(1);
    check("t1_timing_enter", disp_sel, 2'd2);
    check("t1_timing_elapsed0", elapsed_ms, 0);
    ticks(237);
    check("t1_elapsed_237", elapsed_ms, 237);
    p1_press = 1'b1;
    step();
    p1_press = 1'b0;
    check("t1_win_disp", disp_sel, 2'd3);
    check("t1_winner_id", winner_id, 1);
    check("t1_winner_time", winner_time, 237);
    check("t1_score1", score1, 5'b00001);
    check("t1_busy_low", busy, 0);
    step();

    // 2: clamped wait of 6000
    rnd_value = 14'h3FFF;
    pulse_start();
    ticks(3000);
    ticks(5999);
    check("t2_wait_5999", disp_sel, 2'd1);
    ticks(1);
    check("t2_timing_6000", disp_sel, 2'd2);

    // 3: P2 held from blink into wait is a cheat; both pressed gives fill 8
    rnd_value = 14'd0;
    p2_press = 1'b1;
    pulse_start();
    ticks(3000);
    check("t3_wait_first", fill_digit, 4'hF);
    step();
    check("t3_cheat_disp", disp_sel, 2'd1);
    check("t3_cheat_fill", fill_digit, 4'd2);
    check("t3_cheat_score1", score1, 5'b00011);
    check("t3_cheat_score2", score2, 5'b00000);
    p2_press = 1'b0;
    step();
    pulse_start();
    ticks(3000);
    p1_press = 1'b1;
    p2_press = 1'b1;
    step();
    p1_press = 1'b0;
    p2_press = 1'b0;
    check("t3_both_fill", fill_digit, 4'd8);
    check("t3_both_scores", {score1, score2}, {5'b00011, 5'b00000});
    step();

    // 4: tie at 412, then timeout at 9999
    pulse_start();
    ticks(4000);
    ticks(412);
    p1_press = 1'b1;
    p2_press = 1'b1;
    step();
    p1_press = 1'b0;
    p2_press = 1'b0;
    check("t4_tie_id", winner_id, 3);
    check("t4_tie_time", winner_time, 412);
    check("t4_tie_scores", {score1, score2}, {5'b00011, 5'b00000});
    step();
    pulse_start();
    check("t4_start_clears_id", winner_id, 0);
    check("t4_start_clears_time", winner_time, 0);
    ticks(4000);
    ticks(9998);
    check("t4_elapsed_9998", elapsed_ms, 9998);
    check("t4_not_timed_out", disp_sel, 2'd2);
    ticks(1);
    check("t4_timeout_disp", disp_sel, 2'd3);
    check("t4_timeout_id", winner_id, 0);
    check("t4_timeout_time", winner_time, 9999);

    // 5: seven P1 wins saturate score1
    do_reset();
    for (int r = 0; r < 7; r++) begin
      pulse_start();
      ticks(4000);
      ticks(5);
      p1_press = 1'b1;
      step();
      p1_press = 1'b0;
      check("t5_winner_id", winner_id, 1);
      check($sformatf("t5_score1_win%0d", r + 1), score1, therm[r]);
      step();
    end
    pulse_start();
    check("t5_restart_disp", disp_sel, 2'd0);
    check("t5_restart_score", score1, 5'b11111);

    // 6: reset mid-timing, then start beats a coincident press
    ticks(4000);
    ticks(50);
    check("t6_in_timing", disp_sel, 2'd2);
    reset = 1'b1;
    #1;
    check("t6_rst_disp", disp_sel, 2'd1);
    check("t6_rst_elapsed", elapsed_ms, 0);
    check("t6_rst_scores", {score1, score2}, 0);
    check("t6_rst_busy", busy, 0);
    step();
    reset = 1'b0;
    step();
    pulse_start();
    ticks(3000);
    start = 1'b1;
    p1_press = 1'b1;
    step();
    start = 1'b0;
    p1_press = 1'b0;
    check("t6_start_press_disp", disp_sel, 2'd0);
    check("t6_start_press_scores", {score1, score2}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1);
  end

endmodule
